// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - registered immediate extension stage with a 2-entry skid buffer
module imm_extend_pipe #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int TAG_W    = 5,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] xfer_count
);

  localparam logic [1:0] MODE_SIGN  = 2'b00;
  localparam logic [1:0] MODE_ZERO  = 2'b01;
  localparam logic [1:0] MODE_UPPER = 2'b10;

  // A branch offset must never lose bits when shifted, so reject such a build.
  generate
    if (OUT_W < IN_W + BR_SHIFT) begin : g_param_check
      $error("imm_extend_pipe: OUT_W must be >= IN_W + BR_SHIFT");
    end
  endgenerate

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] ext_data;

  // Skid entry: only ever occupied while the main register is also full.
  logic             s_valid;
  logic [OUT_W-1:0] s_data;
  logic [1:0]       s_mode;
  logic [TAG_W-1:0] s_tag;

  logic in_xfer;
  logic m_free;

  // in_ready depends only on the registered skid flag, never on out_ready.
  assign in_ready = !s_valid;
  assign in_xfer  = in_valid && in_ready;
  // The main register can take a new value when it is empty or draining this edge.
  assign m_free   = !out_valid || out_ready;

  // Input-side extension, shared by both storage slots.
  always_comb begin
    sext = OUT_W'($signed(in_imm));
    zext = OUT_W'(in_imm);
    case (in_mode)
      MODE_SIGN:  ext_data = sext;
      MODE_ZERO:  ext_data = zext;
      MODE_UPPER: ext_data = zext << (OUT_W - IN_W);
      default:    ext_data = sext << BR_SHIFT;
    endcase
  end

  // Main/skid register update and accepted-transfer counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_mode   <= '0;
      out_tag    <= '0;
      s_valid    <= 1'b0;
      s_data     <= '0;
      s_mode     <= '0;
      s_tag      <= '0;
      xfer_count <= '0;
    end else begin
      if (in_xfer) begin
        xfer_count <= xfer_count + CNT_W'(1);
      end
      if (m_free) begin
        if (s_valid) begin
          // Skid drains first to keep FIFO order; no input is taken this edge.
          out_valid <= 1'b1;
          out_data  <= s_data;
          out_mode  <= s_mode;
          out_tag   <= s_tag;
          s_valid   <= 1'b0;
        end else if (in_xfer) begin
          out_valid <= 1'b1;
          out_data  <= ext_data;
          out_mode  <= in_mode;
          out_tag   <= in_tag;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (in_xfer) begin
        // Downstream stalled with M full: park the new item in the skid slot.
        s_valid <= 1'b1;
        s_data  <= ext_data;
        s_mode  <= in_mode;
        s_tag   <= in_tag;
      end
    end
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, registered immediate-extension stage for the multi-cycle datapath.
- Takes an IN_W-bit instruction immediate plus a mode select and produces an OUT_W-bit operand. Modes: sign-extend, zero-extend, upper-load placement, branch-offset (sign-extend then shift left).
- Sits between instruction-register decode and the ALU-B operand mux.
- Uses a valid/ready handshake with a 2-entry skid buffer, so the controller can stall downstream without losing an immediate.

Parameters:
- IN_W, 16: immediate input width.
- OUT_W, 32: extended output width. Must satisfy OUT_W >= IN_W + BR_SHIFT, otherwise elaboration is illegal.
- BR_SHIFT, 2: left-shift amount applied in branch mode.
- TAG_W, 5: width of the sideband tag (destination register number) carried with each item.
- CNT_W, 16: width of the accepted-transfer counter.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: synchronous reset, active low.
- in_valid, input, 1: the input item is valid.
- in_ready, output, 1: the block can accept an input item.
- in_imm, input, IN_W: raw immediate.
- in_mode, input, 2: 00 SIGN, 01 ZERO, 10 UPPER, 11 BRANCH.
- in_tag, input, TAG_W: sideband tag, passed through unmodified.
- out_valid, output, 1: the output item is valid.
- out_ready, input, 1: downstream accepts the output.
- out_data, output, OUT_W: extended value.
- out_mode, output, 2: mode used for out_data.
- out_tag, output, TAG_W: tag belonging to out_data.
- xfer_count, output, CNT_W: number of accepted input transfers.

Behaviour:
- Reset is sampled only on a rising clk edge while rst_n=0.
  - Reset clears out_valid, out_data, out_mode, out_tag, xfer_count, and the skid entry (valid bit and contents) to 0.
  - in_ready is 1 after reset.
  - While rst_n=0, in_valid is ignored: no transfer and no count.
  - Reset mid-stream discards both the held output and the skid entry.
- Extension is combinational on the input side; the result is registered. Latency is 1 cycle: an item accepted at edge N appears on out_* after edge N.
  - SIGN: {(OUT_W-IN_W) copies of in_imm[IN_W-1], in_imm}.
  - ZERO: {(OUT_W-IN_W) zeros, in_imm}.
  - UPPER: in_imm in bits [OUT_W-1:OUT_W-IN_W], zeros below.
  - BRANCH: sign-extend to OUT_W, then shift left by BR_SHIFT with zero fill. Truncation is impossible because of the parameter constraint.
- Handshake:
  - An input transfer occurs on an edge where in_valid && in_ready.
  - An output transfer occurs on an edge where out_valid && out_ready.
  - in_ready = !skid_valid. It is a registered value with no combinational path from out_ready.
  - Once out_valid=1, out_data, out_mode and out_tag are held stable until an output transfer.
- Storage: main output register M and skid register S.
  - EMPTY (M empty, S empty):
    - input transfer: item goes to M, state becomes ONE.
  - ONE (M full, S empty):
    - input and output together: new item goes to M, stay in ONE.
    - input only: new item goes to S, state becomes FULL, in_ready drops next cycle.
    - output only: state becomes EMPTY.
  - FULL (M full, S full, in_ready=0):
    - output transfer: S moves to M, state becomes ONE, in_ready rises.
    - no input is possible in this state.
- Ordering is strictly FIFO; no item is ever dropped or duplicated.
- xfer_count increments by 1 on each input transfer and wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Modes, OUT_W=32, out_ready=1: in_imm=0x8004 gives SIGN 0xFFFF8004, ZERO 0x00008004, UPPER 0x80040000, BRANCH 0xFFFE0010, each one cycle after acceptance, with tag 0x1F passed through.
- Stall to FULL: send 3 items (A=0x0001, B=0x0002, C=0x0003, SIGN) with out_ready=0.
  - A sits in M and B in S; in_ready=0 from the cycle after B is accepted; C is held upstream.
  - Raise out_ready: outputs appear in order A, B, C with no loss; xfer_count=3.
- Simultaneous in/out in ONE: continuous in_valid=1 and out_ready=1 for 10 items gives 10 outputs on 10 consecutive cycles; in_ready stays 1 throughout.
- Reset mid-operation: bring the block to FULL, then pull rst_n low for 1 edge.
  - out_valid=0, in_ready=1, xfer_count=0, and the old items never appear.
  - The next accepted item 0x7FFF (SIGN) outputs 0x00007FFF.
- Counter wrap with CNT_W=4: 17 transfers leave xfer_count=1.
- Parameter variant IN_W=12, OUT_W=16, BR_SHIFT=1: in_imm=0x800 gives SIGN 0xF800, ZERO 0x0800, UPPER 0x8000, BRANCH 0xF000.
